// File: rtl/timer_ctrl_if.sv
// ============================================================================
// Module   : timer_ctrl_if
// Brief    : Peripheral load/store bus bundle between the CPU and timer_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface timer_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, irq
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, irq
  );
endinterface

`default_nettype wire

// File: rtl/timer_ctrl.sv
// ============================================================================
// Module   : timer_ctrl
// Brief    : Memory-mapped 32-bit up-counting timer with prescaler and IRQ.
// Revision : 1.0
// ============================================================================
`default_nettype none

module timer_ctrl #(
  parameter logic [31:0] ADDR_TH   = 32'h4000_0000,
  parameter logic [31:0] ADDR_TL   = 32'h4000_0004,
  parameter logic [31:0] ADDR_TCON = 32'h4000_0008,
  parameter logic [31:0] ADDR_PSC  = 32'h4000_000C,
  parameter int          PSC_W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  timer_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        th_q, th_d;
  logic [31:0]        tl_q, tl_d;
  logic [PSC_W-1:0]   psc_q, psc_d;
  logic [PSC_W-1:0]   pc_q, pc_d;
  logic               ie_q, ie_d;
  logic               st_q, st_d;
  logic               os_q, os_d;

  logic wr_th, wr_tl, wr_tcon, wr_psc;
  logic tick, ovf;

  assign wr_th   = bus.mem_write && (bus.addr == ADDR_TH);
  assign wr_tl   = bus.mem_write && (bus.addr == ADDR_TL);
  assign wr_tcon = bus.mem_write && (bus.addr == ADDR_TCON);
  assign wr_psc  = bus.mem_write && (bus.addr == ADDR_PSC);

  assign tick = (state_q == S_RUN) && (pc_q == psc_q);
  // A TL write on a tick edge takes priority and suppresses overflow.
  assign ovf  = tick && !wr_tl && (tl_q == 32'hFFFF_FFFF);

  always_comb begin
    th_d    = th_q;
    tl_d    = tl_q;
    psc_d   = psc_q;
    ie_d    = ie_q;
    st_d    = st_q;
    os_d    = os_q;
    state_d = state_q;

    if (wr_th) th_d = bus.wdata;

    if (wr_tl)     tl_d = bus.wdata;
    else if (ovf)  tl_d = th_q;
    else if (tick) tl_d = tl_q + 32'd1;

    if (wr_psc) psc_d = bus.wdata[PSC_W-1:0];

    if (wr_tcon) begin
      state_d = bus.wdata[0] ? S_RUN : S_IDLE;
      ie_d    = bus.wdata[1];
      os_d    = bus.wdata[3];
      if (bus.wdata[2]) st_d = 1'b0;
    end

    // Overflow set beats a simultaneous W1C so no event is lost.
    if (ovf) begin
      st_d = 1'b1;
      if (os_q) state_d = S_IDLE;
    end

    if ((state_q == S_IDLE) || (state_d == S_IDLE) || wr_psc || tick)
      pc_d = '0;
    else
      pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      th_q    <= '0;
      tl_q    <= '0;
      psc_q   <= '0;
      pc_q    <= '0;
      ie_q    <= 1'b0;
      st_q    <= 1'b0;
      os_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      th_q    <= th_d;
      tl_q    <= tl_d;
      psc_q   <= psc_d;
      pc_q    <= pc_d;
      ie_q    <= ie_d;
      st_q    <= st_d;
      os_q    <= os_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.mem_read) begin
      if (bus.addr == ADDR_TH)        bus.rdata = th_q;
      else if (bus.addr == ADDR_TL)   bus.rdata = tl_q;
      else if (bus.addr == ADDR_TCON) bus.rdata = {28'd0, os_q, st_q, ie_q, (state_q == S_RUN)};
      else if (bus.addr == ADDR_PSC)  bus.rdata = {{(32-PSC_W){1'b0}}, psc_q};
    end
  end

  assign bus.irq = st_q & ie_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
// ============================================================================
// Module   : tb_timer_ctrl
// Brief    : Directed bench for timer_ctrl against a tick-schedule model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_timer_ctrl;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_PSC  = 32'h4000_000C;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic chk_on;

  timer_ctrl_if bus();

  timer_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: registers plus the absolute cycle number of the next tick.
  logic [31:0] m_th, m_tl;
  logic [15:0] m_psc;
  logic        m_en, m_ie, m_st, m_os;
  longint      cyc, nxt;
  logic        wth, wtl, wtc, wps, tick, ovf, ovf_os, was_en;
  logic [31:0] wd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_th = 0; m_tl = 0; m_psc = 0;
      m_en = 0; m_ie = 0; m_st = 0; m_os = 0;
      cyc = 0; nxt = 0;
    end else begin
      cyc    = cyc + 1;
      wd     = bus.wdata;
      wth    = bus.mem_write && (bus.addr == A_TH);
      wtl    = bus.mem_write && (bus.addr == A_TL);
      wtc    = bus.mem_write && (bus.addr == A_TCON);
      wps    = bus.mem_write && (bus.addr == A_PSC);
      tick   = m_en && (cyc == nxt);
      ovf    = tick && !wtl && (m_tl == 32'hFFFF_FFFF);
      ovf_os = ovf && m_os;
      was_en = m_en;
      if (wtl)       m_tl = wd;
      else if (ovf)  m_tl = m_th;
      else if (tick) m_tl = m_tl + 1;
      if (wth) m_th = wd;
      if (wtc) begin
        m_en = wd[0]; m_ie = wd[1]; m_os = wd[3];
        if (wd[2]) m_st = 0;
      end
      if (ovf)    m_st = 1;
      if (ovf_os) m_en = 0;
      if (wps)    m_psc = wd[15:0];
      if (m_en && (!was_en || wps || tick)) nxt = cyc + m_psc + 1;
    end
  end

  function automatic logic [31:0] m_read();
    if (!bus.mem_read)          return 32'd0;
    if (bus.addr == A_TH)       return m_th;
    if (bus.addr == A_TL)       return m_tl;
    if (bus.addr == A_TCON)     return {28'd0, m_os, m_st, m_ie, m_en};
    if (bus.addr == A_PSC)      return {16'd0, m_psc};
    return 32'd0;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      checks = checks + 1;
      if (bus.rdata !== m_read()) begin
        errors = errors + 1;
        $display("FAIL model_rdata t=%0t addr=%h got=%h exp=%h", $time, bus.addr, bus.rdata, m_read());
      end
      checks = checks + 1;
      if (bus.irq !== (m_st & m_ie)) begin
        errors = errors + 1;
        $display("FAIL model_irq t=%0t got=%b exp=%b", $time, bus.irq, m_st & m_ie);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.mem_read = 0; bus.mem_write = 1; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.mem_write = 0; bus.mem_read = 1; bus.addr = A_TL; bus.wdata = 0;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string nm);
    bus.mem_read = 1; bus.addr = a;
    @(negedge clk); #1;
    chk(nm, bus.rdata, exp);
    @(posedge clk); #1;
    bus.addr = A_TL;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0; reset = 0; checks = 0; errors = 0; chk_on = 0;
    bus.mem_read = 1; bus.mem_write = 0; bus.addr = A_TL; bus.wdata = 0;
    #1 reset = 1;
    #1 chk_on = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Reset values and unmapped address.
    rd_chk(A_TH,   32'd0, "rst_th");
    rd_chk(A_TL,   32'd0, "rst_tl");
    rd_chk(A_TCON, 32'd0, "rst_tcon");
    rd_chk(A_PSC,  32'd0, "rst_psc");
    rd_chk(32'h4000_0010, 32'd0, "unmapped");
    chk("rst_irq", {31'd0, bus.irq}, 32'd0);

    // Periodic overflow and reload.
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFC);
    wr(A_PSC, 32'd0);
    wr(A_TCON, 32'h3);
    rd_chk(A_TL, 32'hFFFF_FFFC, "cnt0");
    rd_chk(A_TL, 32'hFFFF_FFFD, "cnt1");
    rd_chk(A_TL, 32'hFFFF_FFFE, "cnt2");
    rd_chk(A_TL, 32'hFFFF_FFFF, "cnt3");
    rd_chk(A_TL, 32'hFFFF_FFFC, "reload");
    chk("irq_ovf", {31'd0, bus.irq}, 32'd1);
    rd_chk(A_TCON, 32'h7, "tcon_st");
    wr(A_TCON, 32'h7);
    chk("irq_w1c", {31'd0, bus.irq}, 32'd0);
    idle(6);

    // W1C colliding with an overflow edge.
    wr(A_TCON, 32'h0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    idle(1);
    wr(A_TCON, 32'h7);
    chk("irq_set_wins", {31'd0, bus.irq}, 32'd1);
    rd_chk(A_TCON, 32'h7, "tcon_set_wins");
    wr(A_TCON, 32'h7);
    chk("irq_w1c2", {31'd0, bus.irq}, 32'd0);

    // Prescaler.
    wr(A_TCON, 32'h0);
    wr(A_PSC, 32'd3);
    wr(A_TL, 32'd0);
    wr(A_TCON, 32'h1);
    for (int i = 0; i < 4; i++) rd_chk(A_TL, 32'd0, "psc3_wait");
    rd_chk(A_TL, 32'd1, "psc3_t1");
    for (int i = 0; i < 3; i++) rd_chk(A_TL, 32'd1, "psc3_hold");
    rd_chk(A_TL, 32'd2, "psc3_t2");
    wr(A_PSC, 32'd1);
    rd_chk(A_TL, 32'd2, "psc1_w0");
    rd_chk(A_TL, 32'd2, "psc1_w1");
    rd_chk(A_TL, 32'd3, "psc1_tick");
    rd_chk(A_PSC, 32'd1, "psc_read");
    idle(5);

    // One-shot.
    wr(A_TCON, 32'h0);
    wr(A_TH, 32'd5);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_PSC, 32'd0);
    wr(A_TCON, 32'hB);
    rd_chk(A_TL, 32'hFFFF_FFFF, "os_pre");
    rd_chk(A_TL, 32'd5, "os_reload");
    rd_chk(A_TCON, 32'hE, "os_tcon");
    idle(20);
    rd_chk(A_TL, 32'd5, "os_frozen");
    rd_chk(A_TH, 32'd5, "th_read");

    // Asynchronous reset while running with irq pending.
    wr(A_TCON, 32'h3);
    idle(3);
    chk("irq_pre_rst", {31'd0, bus.irq}, 32'd1);
    reset = 1;
    #1;
    chk("irq_async_rst", {31'd0, bus.irq}, 32'd0);
    chk("tl_async_rst", bus.rdata, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    rd_chk(A_TCON, 32'd0, "tcon_after_rst");
    idle(5);
    rd_chk(A_TL, 32'd0, "tl_idle_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
